// File: rtl/riscv_pkg.sv
// Shared pipeline types for the fetch stage and the IF/ID boundary.
// The decode stage reuses if_id_t so both sides agree on the register layout.
package riscv_pkg;

    // addi x0,x0,0 -- the canonical no-op placed in IF/ID on bubbles
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    // Contents of IF/ID whenever it carries no real instruction
    localparam if_id_t IF_ID_BUBBLE = '{
        pc:    32'h0,
        pc4:   32'h0,
        inst:  NOP_INST,
        valid: 1'b0
    };

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush wins over hold so a redirect can squash
// the entry even while the hazard unit is stalling the front end.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    // Load, hold or squash the entry; reset leaves a bubble behind
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q <= IF_ID_BUBBLE;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, addresses the instruction memory, checks for
// misaligned / out-of-range fetches and feeds the IF/ID register.
// The memory answers combinationally for the current pc, so the word seen on
// inst_i in a cycle always belongs to imem_addr_o of that same cycle.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 51
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] inst_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_inst_o,
    output logic        if_id_valid_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    fetch_state_e state;
    logic         bad;
    logic         ifid_hold;
    logic         ifid_flush;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    assign pc_plus4 = pc + 32'd4;

    // Fault check looks only at the registered pc
    assign bad = (pc[1:0] != 2'b00) || (pc[31:2] >= DEPTH_WORDS);

    // IF/ID control: anything other than a clean RUN fetch is a bubble or a hold
    always_comb begin
        ifid_d     = '{pc: pc, pc4: pc_plus4, inst: inst_i, valid: 1'b1};
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        case (state)
            RUN: begin
                if (redirect_i || bad) begin
                    ifid_flush = 1'b1;
                end else if (stall_i) begin
                    ifid_hold = 1'b1;
                end
            end
            default: ifid_flush = 1'b1;
        endcase
    end

    // PC, fetch state, fault latch and fetch counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            state         <= BOOT;
            fault_o       <= 1'b0;
            fault_pc_o    <= 32'h0;
            fetch_count_o <= 32'h0;
        end else begin
            case (state)
                BOOT: begin
                    // Give the memory read one cycle to settle; redirect ignored
                    state <= RUN;
                end
                RUN: begin
                    if (redirect_i) begin
                        pc <= redirect_pc_i;
                    end else if (bad) begin
                        fault_o    <= 1'b1;
                        fault_pc_o <= pc;
                        state      <= FAULT;
                    end else if (!stall_i) begin
                        pc            <= pc_plus4;
                        fetch_count_o <= fetch_count_o + 32'd1;
                    end
                end
                FAULT: begin
                    // Only a redirect leaves FAULT; stall has no effect here
                    if (redirect_i) begin
                        pc      <= redirect_pc_i;
                        fault_o <= 1'b0;
                        state   <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst   (rst),
        .hold  (ifid_hold),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr_o   = pc;
    assign if_id_pc_o    = ifid_q.pc;
    assign if_id_pc4_o   = ifid_q.pc4;
    assign if_id_inst_o  = ifid_q.inst;
    assign if_id_valid_o = ifid_q.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Instruction memory word i holds
// 32'h1000_0000 + i. Inputs change on the falling edge, outputs are checked
// on the falling edge after each rising edge.
module tb_instruction_fetch_unit;

    localparam logic [31:0] N = 32'h0000_0013;
    localparam logic [31:0] B = 32'h1000_0000;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] inst_i;
    logic [31:0] imem_addr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;
    logic        fault_o;
    logic [31:0] fault_pc_o;
    logic [31:0] fetch_count_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic        fault;
        logic [31:0] fpc;
        logic [31:0] cnt;
    } vec_t;

    vec_t vq[$];

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (51)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .inst_i        (inst_i),
        .imem_addr_o   (imem_addr_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_inst_o  (if_id_inst_o),
        .if_id_valid_o (if_id_valid_o),
        .fault_o       (fault_o),
        .fault_pc_o    (fault_pc_o),
        .fetch_count_o (fetch_count_o)
    );

    // Combinational instruction memory model
    assign inst_i = B + {2'b00, imem_addr_o[31:2]};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic [31:0] addr,
                                logic [31:0] pc, logic [31:0] pc4, logic [31:0] inst,
                                logic valid, logic fault, logic [31:0] fpc, logic [31:0] cnt);
        vec_t v;
        v.stall = st;   v.redir = rd;   v.rpc = rpc;  v.addr = addr;
        v.pc    = pc;   v.pc4   = pc4;  v.inst = inst; v.valid = valid;
        v.fault = fault; v.fpc  = fpc;  v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " imem_addr"}, imem_addr_o, v.addr);
        check({tag, " if_id_pc"}, if_id_pc_o, v.pc);
        check({tag, " if_id_pc4"}, if_id_pc4_o, v.pc4);
        check({tag, " if_id_inst"}, if_id_inst_o, v.inst);
        check({tag, " if_id_valid"}, {31'b0, if_id_valid_o}, {31'b0, v.valid});
        check({tag, " fault"}, {31'b0, fault_o}, {31'b0, v.fault});
        check({tag, " fault_pc"}, fault_pc_o, v.fpc);
        check({tag, " fetch_count"}, fetch_count_o, v.cnt);
    endtask

    // Apply one vector's inputs, clock once, check its expectations
    task automatic step(input string tag, input vec_t v);
        stall_i       = v.stall;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        @(posedge clk);
        @(negedge clk);
        check_all(tag, v);
    endtask

    initial begin
        vec_t rv;
        rv = mk(0, 0, 0, 0, 0, 0, N, 0, 0, 0, 0);

        //        stall redir rpc       addr      pc        pc4       inst     v  f  fpc       cnt
        vq.push_back(mk(0, 0, 0,        32'h00, 32'h00, 32'h00, N,        0, 0, 0,      0));  // BOOT
        vq.push_back(mk(0, 0, 0,        32'h04, 32'h00, 32'h04, B + 0,    1, 0, 0,      1));
        vq.push_back(mk(0, 0, 0,        32'h08, 32'h04, 32'h08, B + 1,    1, 0, 0,      2));
        vq.push_back(mk(0, 0, 0,        32'h0C, 32'h08, 32'h0C, B + 2,    1, 0, 0,      3));
        vq.push_back(mk(1, 0, 0,        32'h0C, 32'h08, 32'h0C, B + 2,    1, 0, 0,      3));  // stall
        vq.push_back(mk(1, 0, 0,        32'h0C, 32'h08, 32'h0C, B + 2,    1, 0, 0,      3));  // stall
        vq.push_back(mk(0, 0, 0,        32'h10, 32'h0C, 32'h10, B + 3,    1, 0, 0,      4));
        vq.push_back(mk(1, 1, 32'h20,   32'h20, 32'h00, 32'h00, N,        0, 0, 0,      4));  // redirect+stall
        vq.push_back(mk(0, 0, 0,        32'h24, 32'h20, 32'h24, B + 8,    1, 0, 0,      5));
        vq.push_back(mk(0, 1, 32'h22,   32'h22, 32'h00, 32'h00, N,        0, 0, 0,      5));  // misaligned target
        vq.push_back(mk(0, 0, 0,        32'h22, 32'h00, 32'h00, N,        0, 1, 32'h22, 5));  // fault
        vq.push_back(mk(1, 0, 0,        32'h22, 32'h00, 32'h00, N,        0, 1, 32'h22, 5));
        vq.push_back(mk(0, 0, 0,        32'h22, 32'h00, 32'h00, N,        0, 1, 32'h22, 5));
        vq.push_back(mk(1, 0, 0,        32'h22, 32'h00, 32'h00, N,        0, 1, 32'h22, 5));
        vq.push_back(mk(0, 1, 32'h00,   32'h00, 32'h00, 32'h00, N,        0, 0, 32'h22, 5));  // leave FAULT
        vq.push_back(mk(0, 0, 0,        32'h04, 32'h00, 32'h04, B + 0,    1, 0, 32'h22, 6));
        vq.push_back(mk(0, 1, 32'hC0,   32'hC0, 32'h00, 32'h00, N,        0, 0, 32'h22, 6));
        vq.push_back(mk(0, 0, 0,        32'hC4, 32'hC0, 32'hC4, B + 48,   1, 0, 32'h22, 7));
        vq.push_back(mk(0, 0, 0,        32'hC8, 32'hC4, 32'hC8, B + 49,   1, 0, 32'h22, 8));
        vq.push_back(mk(0, 0, 0,        32'hCC, 32'hC8, 32'hCC, B + 50,   1, 0, 32'h22, 9));  // last word
        vq.push_back(mk(0, 0, 0,        32'hCC, 32'h00, 32'h00, N,        0, 1, 32'hCC, 9));  // out of range
        vq.push_back(mk(0, 1, 32'h10,   32'h10, 32'h00, 32'h00, N,        0, 0, 32'hCC, 9));
        vq.push_back(mk(0, 0, 0,        32'h14, 32'h10, 32'h14, B + 4,    1, 0, 32'hCC, 10));

        // Reset block
        rst           = 1'b1;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        repeat (2) @(negedge clk);
        check_all("reset", rv);
        rst = 1'b0;

        foreach (vq[i]) step($sformatf("vec%0d", i), vq[i]);

        // Asynchronous reset mid-cycle at pc=0x14, checked before the next edge
        #2 rst = 1'b1;
        #1 check_all("async_rst", rv);
        @(negedge clk);
        rst = 1'b0;

        // BOOT after reset ignores a redirect and holds RESET_PC
        step("boot_redir", mk(0, 1, 32'h40, 32'h00, 32'h00, 32'h00, N, 0, 0, 0, 0));
        step("restart",    mk(0, 0, 0,      32'h04, 32'h00, 32'h04, B, 1, 0, 0, 1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
IF-stage initiator for the pipeline's instruction memory. It owns the PC and drives a byte address to the memory. The memory returns the word at index imem_addr_o[31:2] combinationally in the same cycle. The unit captures that word into the IF/ID pipeline register and handles stall, branch/jump redirect, and fetch faults (misaligned or out-of-range address). It sits between the instruction memory and the decode stage, and takes control inputs from the hazard unit and the EX stage.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
IMEM_DEPTH, 51, number of 32-bit words in instruction memory; valid word indices are 0..IMEM_DEPTH-1
NOP_INST, 32'h0000_0013, addi x0,x0,0, driven into IF/ID on bubbles

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
stall_i  input  1  hazard unit: hold PC and IF/ID
redirect_i  input  1  EX stage: taken branch/jump, flush IF/ID
redirect_pc_i  input  32  target byte address when redirect_i=1
inst_i  input  32  instruction word from memory for imem_addr_o
imem_addr_o  output  32  byte fetch address, equals current PC
if_id_pc_o  output  32  PC of instruction held in IF/ID
if_id_pc4_o  output  32  if_id_pc_o + 4, modulo 2^32
if_id_inst_o  output  32  instruction held in IF/ID
if_id_valid_o  output  1  IF/ID holds a real instruction
fault_o  output  1  fetch fault latched; FSM in FAULT
fault_pc_o  output  32  address that caused the fault
fetch_count_o  output  32  number of instructions written to IF/ID with valid=1, wraps at 2^32

Behaviour:
- Reset (async, while rst=1): the following values apply.
  - pc=RESET_PC and state=BOOT.
  - if_id_pc_o=0, if_id_pc4_o=0, if_id_inst_o=NOP_INST, if_id_valid_o=0.
  - fault_o=0, fault_pc_o=0, fetch_count_o=0.
  - Reset asserted mid-operation discards all in-flight state on the same edge.
- Fetch-fault condition: bad = (pc[1:0]!=0) or (pc[31:2] >= IMEM_DEPTH). It is evaluated combinationally on the current pc.
- FSM states: BOOT, RUN, FAULT.
  - BOOT: lasts exactly one cycle after rst deasserts. IF/ID is loaded with a bubble and pc holds, so the memory read settles. Next state is RUN. redirect_i is ignored in BOOT.
  - RUN: edge actions apply in priority order redirect > bad > stall > normal.
    - redirect_i=1: pc<=redirect_pc_i and IF/ID<=bubble, even if stall_i=1. Stays in RUN. A bad target is detected the next cycle.
    - bad (no redirect): fault_pc_o<=pc and fault_o<=1. IF/ID<=bubble and pc holds. Next state is FAULT.
    - stall_i=1: pc and all IF/ID fields hold. fetch_count_o holds.
    - Normal: IF/ID<={pc, pc+4, inst_i, valid=1}, pc<=pc+4 (wraps 32'hFFFF_FFFC -> 0), and fetch_count_o increments.
  - FAULT: pc holds, IF/ID stays bubble, fault_o=1, and stall_i is ignored.
    - redirect_i=1: pc<=redirect_pc_i, fault_o<=0, next state RUN. fault_pc_o retains its last value.
- Bubble: valid=0, inst=NOP_INST, pc and pc4 fields set to 0.
- Latency: an instruction at address A appears on if_id_* one edge after imem_addr_o=A in RUN with no stall, redirect or fault.
- Throughput: 1 instruction per cycle.
- Redirect penalty: the IF/ID entry on the edge of redirect is a bubble. The target instruction is valid one cycle later.
- imem_addr_o is a pure function of the pc register and has no combinational path from inputs.
- if_id_pc4_o is registered, not computed on the output.

Decomposition:
- Shared package (riscv_pkg): NOP_INST constant, a fetch_state_e enum {BOOT, RUN, FAULT}, and an if_id_t packed struct {pc, pc4, inst, valid}. The decode stage reuses if_id_t.
- One natural sub-module: if_id_reg. It is the IF/ID pipeline register with hold (stall) and flush (bubble) controls, plus the async active-high reset to bubble.
- PC, FSM, fault check and counter stay in instruction_fetch_unit.

Test Plan:
- Reset, release, memory word i = 32'h1000_0000+i:
  - BOOT cycle gives valid=0.
  - Then if_id_pc = 0, 4, 8 with inst = 32'h1000_0000, _0001, _0002 on consecutive cycles.
  - fetch_count = 3.
- Stall for 2 cycles while pc=0x0C: imem_addr_o stays 0x0C and if_id_pc stays 0x08 with valid=1. The cycle after stall drops gives if_id_pc=0x0C, and fetch_count does not change during the stall.
- Redirect to 0x20 asserted with stall_i=1:
  - Next cycle: valid=0 and inst=32'h0000_0013.
  - Following cycle: if_id_pc=0x20, if_id_pc4=0x24, valid=1.
- Redirect to 0x22:
  - One cycle later imem_addr_o=0x22.
  - The next edge gives fault_o=1, fault_pc_o=0x22, valid=0.
  - FAULT holds with stall toggling.
  - Redirect to 0x00 clears fault_o and resumes at 0x00.
- Sequential fetch reaching 0xC8 then 0xCC (word 51 ≥ IMEM_DEPTH): the 0xC8 instruction is valid, then fault_pc_o=0xCC with fault_o=1.
- Assert rst asynchronously mid-fetch at pc=0x14: outputs go to reset values before the next clock edge, and after release fetch restarts from RESET_PC via BOOT.
